toss_sched: RTL and testbench

Round-robin scheduler that shares a single 8-state coin-toss generator among NREQ requesters. Each granted requester gets exclusive use of the generator for a programmed number of steps in a latched direction, then receives the final 3-bit generator state through a valid/ready result port. Sits between requesting client logic and the toss generator datapath.

---
 rtl/toss_pkg.sv | 21 ++
 rtl/toss_sched_if.sv | 38 +++
 rtl/toss_step_fsm.sv | 41 ++++
 rtl/toss_sched.sv | 122 ++++++++++++
 tb/tb_toss_sched.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/toss_pkg.sv
// toss_pkg: shared constants and types for the coin-toss scheduler.
//   S0..S7       : 3-bit generator state encodings
//   ctrl_state_t : controller states IDLE / RUN / DONE
package toss_pkg;

   localparam logic [2:0] S0 = 3'd0;
   localparam logic [2:0] S1 = 3'd1;
   localparam logic [2:0] S2 = 3'd2;
   localparam logic [2:0] S3 = 3'd3;
   localparam logic [2:0] S4 = 3'd4;
   localparam logic [2:0] S5 = 3'd5;
   localparam logic [2:0] S6 = 3'd6;
   localparam logic [2:0] S7 = 3'd7;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } ctrl_state_t;

endpackage

// File: rtl/toss_sched_if.sv
// toss_sched_if: request/grant and result signals of the toss scheduler.
//   master : client side (drives req, req_dir, req_steps, done_ready)
//   slave  : scheduler side (drives gnt, busy, done_*, gen_state, dbg_state)
// Result handshake: done_valid/done_id/done_val are held stable while
// done_valid=1; the result is consumed at a rising clk edge where
// done_valid=1 and done_ready=1, and done_valid cannot rise again in the
// same transaction. done_ready may be high at any time.
interface toss_sched_if #(
   parameter int NREQ = 4,
   parameter int SW   = 4
);
   import toss_pkg::*;

   localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

   logic [NREQ-1:0]    req;
   logic [NREQ-1:0]    req_dir;
   logic [NREQ*SW-1:0] req_steps;
   logic [NREQ-1:0]    gnt;
   logic               busy;
   logic               done_valid;
   logic               done_ready;
   logic [IDW-1:0]     done_id;
   logic [2:0]         done_val;
   logic [2:0]         gen_state;
   ctrl_state_t        dbg_state;

   modport master (
      output req, req_dir, req_steps, done_ready,
      input  gnt, busy, done_valid, done_id, done_val, gen_state, dbg_state
   );

   modport slave (
      input  req, req_dir, req_steps, done_ready,
      output gnt, busy, done_valid, done_id, done_val, gen_state, dbg_state
   );

endinterface

// File: rtl/toss_step_fsm.sv
// toss_step_fsm: 8-state coin-toss generator.
//   clk, rst : clock, asynchronous active-high reset (state -> S0)
//   step     : advance one transition this cycle
//   dir      : transition direction used when step=1
//   state    : current generator state
module toss_step_fsm
   import toss_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       step,
   input  logic       dir,
   output logic [2:0] state
);

   function automatic logic [2:0] next_state(input logic [2:0] cur, input logic d);
      logic [2:0] nxt;
      nxt = cur;
      case (cur)
         S0: nxt = d ? S1 : S2;
         S1: nxt = d ? S3 : S2;
         S2: nxt = d ? S3 : S4;
         S3: nxt = d ? S5 : S4;
         S4: nxt = d ? S5 : S6;
         S5: nxt = d ? S7 : S6;
         S6: nxt = d ? S7 : S0;
         S7: nxt = d ? S0 : S2;
         default: nxt = S0;
      endcase
      return nxt;
   endfunction

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= S0;
      end else if (step) begin
         state <= next_state(state, dir);
      end
   end

endmodule

// File: rtl/toss_sched.sv
// toss_sched: round-robin scheduler sharing one toss generator among NREQ
// requesters. A winner gets the generator for its programmed step count in
// its sampled direction, then its final state is offered on the result port.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : toss_sched_if.slave (req/req_dir/req_steps in, gnt out,
//              busy, done_valid/done_ready/done_id/done_val result port,
//              gen_state live generator state, dbg_state controller state)
module toss_sched
   import toss_pkg::*;
#(
   parameter int NREQ = 4,
   parameter int SW   = 4
) (
   input  logic         clk,
   input  logic         rst,
   toss_sched_if.slave  bus
);

   localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

   ctrl_state_t     st;
   logic [IDW-1:0]  ptr;
   logic [IDW-1:0]  id_q;
   logic [SW-1:0]   cnt;
   logic            dir_q;
   logic [NREQ-1:0] gnt_q;
   logic            busy_q;
   logic            done_valid_q;
   logic [IDW-1:0]  done_id_q;
   logic [2:0]      done_val_q;
   logic [2:0]      gen_state;
   logic            gen_step;

   logic            win_found;
   logic [IDW-1:0]  win_id;
   logic [NREQ-1:0] win_oh;
   int              idx;

   // First set request at or above ptr, wrapping past the top index.
   always_comb begin
      win_found = 1'b0;
      win_id    = '0;
      win_oh    = '0;
      idx       = 0;
      for (int k = 0; k < NREQ; k++) begin
         idx = (int'(ptr) + k) % NREQ;
         if (!win_found && bus.req[idx]) begin
            win_found = 1'b1;
            win_id    = IDW'(idx);
         end
      end
      win_oh[win_id] = win_found;
   end

   // The generator only moves while a transaction still has steps left.
   assign gen_step = (st == RUN) && (cnt != '0);

   toss_step_fsm u_gen (
      .clk   (clk),
      .rst   (rst),
      .step  (gen_step),
      .dir   (dir_q),
      .state (gen_state)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         st           <= IDLE;
         ptr          <= '0;
         id_q         <= '0;
         cnt          <= '0;
         dir_q        <= 1'b0;
         gnt_q        <= '0;
         busy_q       <= 1'b0;
         done_valid_q <= 1'b0;
         done_id_q    <= '0;
         done_val_q   <= '0;
      end else begin
         gnt_q <= '0;
         case (st)
            IDLE: begin
               if (win_found) begin
                  gnt_q  <= win_oh;
                  dir_q  <= bus.req_dir[win_id];
                  cnt    <= bus.req_steps[int'(win_id)*SW +: SW];
                  id_q   <= win_id;
                  busy_q <= 1'b1;
                  st     <= RUN;
               end
            end
            RUN: begin
               if (cnt != '0) begin
                  cnt <= cnt - 1'b1;
               end else begin
                  done_val_q   <= gen_state;
                  done_id_q    <= id_q;
                  done_valid_q <= 1'b1;
                  st           <= DONE;
               end
            end
            DONE: begin
               if (bus.done_ready) begin
                  done_valid_q <= 1'b0;
                  busy_q       <= 1'b0;
                  ptr          <= (int'(id_q) == NREQ - 1) ? '0 : id_q + 1'b1;
                  st           <= IDLE;
               end
            end
            default: st <= IDLE;
         endcase
      end
   end

   assign bus.gnt        = gnt_q;
   assign bus.busy       = busy_q;
   assign bus.done_valid = done_valid_q;
   assign bus.done_id    = done_id_q;
   assign bus.done_val   = done_val_q;
   assign bus.gen_state  = gen_state;
   assign bus.dbg_state  = st;

endmodule

// File: tb/tb_toss_sched.sv
// tb_toss_sched: directed bench for toss_sched (NREQ=4, SW=4).
module tb_toss_sched;
   import toss_pkg::*;

   logic clk = 1'b0;
   logic rst;
   int   checks   = 0;
   int   failures = 0;
   int   cyc_cnt  = 0;
   int   last_gnt_cyc = 0;

   logic [4:0] exp_q[$];

   toss_sched_if #(.NREQ(4), .SW(4)) bus ();

   toss_sched #(.NREQ(4), .SW(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;
   always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   // ---------------- checking ----------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // ---------------- driver ----------------
   // One full transaction: present request, wait for grant, wait for result,
   // optionally stall the consumer for hold cycles, then accept.
   task automatic run_txn(input logic [3:0] r, input logic [3:0] d, input logic [15:0] s,
                          input int exp_id, input logic [2:0] exp_val, input int n,
                          input bit drop, input int hold);
      int         cyc;
      bit         seen;
      bit         extra_gnt;
      logic [4:0] rec;
      bus.req        = r;
      bus.req_dir    = d;
      bus.req_steps  = s;
      bus.done_ready = (hold == 0);
      exp_q.push_back({2'(exp_id), exp_val});
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge clk);
         if (bus.gnt != '0) seen = 1'b1;
      end
      if (!seen) begin
         check("gnt_timeout", 32'd0, 32'd1);
         void'(exp_q.pop_front());
         return;
      end
      last_gnt_cyc = cyc_cnt;
      check("gnt_onehot", 32'(bus.gnt), 32'(1 << exp_id));
      check("busy_run", 32'(bus.busy), 32'd1);
      if (drop) bus.req = '0;
      cyc = 0;
      extra_gnt = 1'b0;
      seen = 1'b0;
      while (!seen && cyc < 40) begin
         @(negedge clk);
         cyc++;
         if (bus.gnt != '0) extra_gnt = 1'b1;
         if (bus.done_valid) seen = 1'b1;
      end
      check("gnt_pulse", 32'(extra_gnt), 32'd0);
      if (!seen) begin
         check("done_timeout", 32'd0, 32'd1);
         void'(exp_q.pop_front());
         return;
      end
      check("done_latency", 32'(cyc), 32'(n + 1));
      rec = exp_q.pop_front();
      check("done_id", 32'(bus.done_id), 32'(rec[4:3]));
      check("done_val", 32'(bus.done_val), 32'(rec[2:0]));
      check("gen_hold", 32'(bus.gen_state), 32'(rec[2:0]));
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         check("hold_valid", 32'(bus.done_valid), 32'd1);
         check("hold_id", 32'(bus.done_id), 32'(rec[4:3]));
         check("hold_val", 32'(bus.done_val), 32'(rec[2:0]));
         check("hold_nognt", 32'(bus.gnt), 32'd0);
         check("hold_busy", 32'(bus.busy), 32'd1);
      end
      bus.done_ready = 1'b1;
      @(negedge clk);
      check("accept_valid", 32'(bus.done_valid), 32'd0);
      check("accept_busy", 32'(bus.busy), 32'd0);
      check("accept_state", 32'(bus.dbg_state), 32'(IDLE));
   endtask

   // ---------------- vectors ----------------
   typedef struct {
      logic [3:0]  req;
      logic [3:0]  dir;
      logic [15:0] steps;
      int          exp_id;
      logic [2:0]  exp_val;
      int          n;
   } vec_t;

   vec_t       vecs[6];
   logic [2:0] rr_val[5];
   int         prev_gnt;
   bit         seen;

   initial begin
      // Generator is carried across vectors: 0 -dir0x4-> 0 -x0-> 0 -dir1x3-> 5
      // -dir0x2-> 0 -dir1x1-> 1 -dir1x5-> 1. ptr: 1,1,1,3,0,2.
      vecs[0] = '{req: 4'b0001, dir: 4'b0000, steps: 16'h0004, exp_id: 0, exp_val: 3'd0, n: 4};
      vecs[1] = '{req: 4'b0001, dir: 4'b1111, steps: 16'h0000, exp_id: 0, exp_val: 3'd0, n: 0};
      vecs[2] = '{req: 4'b0001, dir: 4'b1111, steps: 16'h0003, exp_id: 0, exp_val: 3'd5, n: 3};
      vecs[3] = '{req: 4'b0100, dir: 4'b0000, steps: 16'h0200, exp_id: 2, exp_val: 3'd0, n: 2};
      vecs[4] = '{req: 4'b1010, dir: 4'b1111, steps: 16'h1090, exp_id: 3, exp_val: 3'd1, n: 1};
      vecs[5] = '{req: 4'b1010, dir: 4'b1111, steps: 16'h9050, exp_id: 1, exp_val: 3'd1, n: 5};
      rr_val[0] = 3'd1; rr_val[1] = 3'd3; rr_val[2] = 3'd5; rr_val[3] = 3'd7; rr_val[4] = 3'd0;

      rst = 1'b1;
      bus.req = '0;
      bus.req_dir = '0;
      bus.req_steps = '0;
      bus.done_ready = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_gnt", 32'(bus.gnt), 32'd0);
      check("rst_busy", 32'(bus.busy), 32'd0);
      check("rst_valid", 32'(bus.done_valid), 32'd0);
      check("rst_id", 32'(bus.done_id), 32'd0);
      check("rst_val", 32'(bus.done_val), 32'd0);
      check("rst_gen", 32'(bus.gen_state), 32'd0);
      check("rst_state", 32'(bus.dbg_state), 32'(IDLE));
      rst = 1'b0;
      @(negedge clk);
      check("idle_no_req_gnt", 32'(bus.gnt), 32'd0);

      for (int i = 0; i < 6; i++) begin
         run_txn(vecs[i].req, vecs[i].dir, vecs[i].steps, vecs[i].exp_id,
                 vecs[i].exp_val, vecs[i].n, 1'b1, 0);
      end

      // Consumer stall: ptr=2, only req0 -> id0, gen 1 -dir1x2-> 5.
      run_txn(4'b0001, 4'b0001, 16'h0002, 0, 3'd5, 2, 1'b1, 5);

      // Reset in the middle of a 7-step run after 3 steps: gen 5 -> 6 -> 0 -> 2.
      bus.req = 4'b0001;
      bus.req_dir = 4'b0000;
      bus.req_steps = 16'h0007;
      bus.done_ready = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge clk);
         if (bus.gnt != '0) seen = 1'b1;
      end
      check("mid_gnt", 32'(bus.gnt), 32'b0001);
      bus.req = '0;
      repeat (3) @(negedge clk);
      check("mid_gen_pre", 32'(bus.gen_state), 32'd2);
      check("mid_state_pre", 32'(bus.dbg_state), 32'(RUN));
      rst = 1'b1;
      #1;
      check("mid_rst_gen", 32'(bus.gen_state), 32'd0);
      check("mid_rst_busy", 32'(bus.busy), 32'd0);
      check("mid_rst_valid", 32'(bus.done_valid), 32'd0);
      check("mid_rst_state", 32'(bus.dbg_state), 32'(IDLE));
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("post_rst_valid", 32'(bus.done_valid), 32'd0);
      end

      // Round robin with all requesting from ptr=0, gen S0, one step each.
      prev_gnt = 0;
      for (int i = 0; i < 5; i++) begin
         run_txn(4'hF, 4'hF, 16'h1111, i % 4, rr_val[i], 1, 1'b0, 0);
         if (i > 0) check("rr_gap", 32'(last_gnt_cyc - prev_gnt), 32'd4);
         prev_gnt = last_gnt_cyc;
      end

      // req[2] withdrawn right after its grant; ptr=1, gen 0 -dir0x3-> 6.
      run_txn(4'b0100, 4'b0000, 16'h0300, 2, 3'd6, 3, 1'b1, 0);

      check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
